// File: rtl/shiftreg_pkg.sv
// Shared definitions for the self-stimulating shift register system.
//
// Contents:
//   WIDTH     - default word width of the generator, shift register and output
//   CNT_W     - bit counter width for the default WIDTH
//   SEED      - first word transmitted after reset
//   word_t    - word type at the default width
//   cnt_width - counter width for an arbitrary word width (never below 1)
package shiftreg_pkg;

  localparam int WIDTH = 24;
  localparam int CNT_W = $clog2(WIDTH);
  localparam int SEED  = 1;

  typedef logic [WIDTH-1:0] word_t;

  // A one-bit word still needs a one-bit counter, so clamp $clog2 at 1.
  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/shift_reg_sipo.sv
// Serial-in / parallel-out shift register with a one-cycle capture strobe.
//
// Ports:
//   clk           - system clock, all state on the rising edge
//   reset_i       - asynchronous active-high reset
//   serial_in     - serial bit, MSB of each word first
//   capture       - high on the cycle the last bit of a word is presented
//   dout_parallel - last completed word; holds its value between captures
//   trigger       - registered pulse, high for exactly the one cycle in which
//                   dout_parallel shows a newly captured word
//
// The capture path takes the incoming bit directly rather than waiting a
// cycle for it to land in sr, so the completed word appears on the same edge
// as the final shift.
module shift_reg_sipo #(
  parameter int WIDTH = 24
) (
  input  logic             clk,
  input  logic             reset_i,
  input  logic             serial_in,
  input  logic             capture,
  output logic [WIDTH-1:0] dout_parallel,
  output logic             trigger
);

  logic [WIDTH-1:0] sr;
  logic [WIDTH-1:0] sr_next;

  assign sr_next = {sr[WIDTH-2:0], serial_in};

  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      sr            <= '0;
      dout_parallel <= '0;
      trigger       <= 1'b0;
    end else begin
      sr      <= sr_next;
      trigger <= capture;
      if (capture) begin
        dout_parallel <= sr_next;
      end
    end
  end

endmodule

// File: rtl/top_system_shiftreg.sv
// Self-stimulating word generator feeding a serial-in / parallel-out register.
//
// Ports:
//   clk     - system clock, all state on the rising edge
//   reset_i - asynchronous active-high reset
//
// There are no outputs. The observable state lives in internal signals that
// are probed hierarchically:
//   trigger       - one-cycle pulse when a word has been captured
//   data_in_vec   - word currently being transmitted (starts at SEED)
//   dout_parallel - last captured word
//   bit_cnt       - position within the current word, 0..WIDTH-1
//
// Each word is sent MSB first over WIDTH cycles. On the last bit the generator
// advances, the counter wraps and the sub-module captures, all on one edge, so
// words stream back to back with no idle cycles.
module top_system_shiftreg #(
  parameter int WIDTH = 24
) (
  input logic clk,
  input logic reset_i
);

  import shiftreg_pkg::*;

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  logic [WIDTH-1:0] data_in_vec;
  logic [CW-1:0]    bit_cnt;
  logic [CW-1:0]    bit_idx;
  logic             serial_bit;
  logic             last_bit;
  logic [WIDTH-1:0] dout_parallel;
  logic             trigger;

  // Bit 0 of the count selects the MSB of the word.
  assign bit_idx    = LAST_BIT - bit_cnt;
  assign serial_bit = data_in_vec[bit_idx];
  assign last_bit   = (bit_cnt == LAST_BIT);

  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      data_in_vec <= WIDTH'(SEED);
      bit_cnt     <= '0;
    end else if (last_bit) begin
      // Unsigned add wraps all-ones back to zero.
      data_in_vec <= data_in_vec + 1'b1;
      bit_cnt     <= '0;
    end else begin
      bit_cnt <= bit_cnt + 1'b1;
    end
  end

  shift_reg_sipo #(
    .WIDTH (WIDTH)
  ) u_sipo (
    .clk           (clk),
    .reset_i       (reset_i),
    .serial_in     (serial_bit),
    .capture       (last_bit),
    .dout_parallel (dout_parallel),
    .trigger       (trigger)
  );

endmodule

// File: tb/tb_top_system_shiftreg.sv
// Directed bench for top_system_shiftreg. The bench keeps its own model of the
// generator, bit position and shift register; each started word is pushed to
// exp_q and popped when the design is expected to capture it.
module tb_top_system_shiftreg;

  localparam int W = 24;

  logic clk;
  logic reset_i;

  top_system_shiftreg #(.WIDTH(W)) dut (
    .clk     (clk),
    .reset_i (reset_i)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard / model ----------------
  logic [W-1:0] exp_q[$];
  logic [W-1:0] m_word;
  logic [W-1:0] m_sr;
  logic [W-1:0] m_dout;
  int           m_cnt;
  int           n_trig;
  int           n_pass;
  int           n_chk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_chk++;
    assert (obs === exp_v) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
  endtask

  task automatic model_reset();
    m_word = W'(1);
    m_sr   = '0;
    m_dout = '0;
    m_cnt  = 0;
    exp_q.delete();
  endtask

  // One rising edge, then compare every observable against the model.
  task automatic tick();
    logic sbit;
    logic exp_trig;
    if (m_cnt == 0) exp_q.push_back(m_word);
    sbit = m_word[W-1-m_cnt];
    @(posedge clk);
    #1;
    m_sr = {m_sr[W-2:0], sbit};
    exp_trig = (m_cnt == W-1);
    if (exp_trig) begin
      if (exp_q.size() > 0) m_dout = exp_q.pop_front();
      m_word = m_word + 1'b1;
      m_cnt  = 0;
      n_trig++;
    end else begin
      m_cnt++;
    end
    chk("trigger", 32'(dut.trigger), 32'(exp_trig));
    chk("dout_parallel", 32'(dut.dout_parallel), 32'(m_dout));
    chk("data_in_vec", 32'(dut.data_in_vec), 32'(m_word));
    chk("bit_cnt", 32'(dut.bit_cnt), 32'(m_cnt));
    chk("sr", 32'(dut.u_sipo.sr), 32'(m_sr));
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_data"}, 32'(dut.data_in_vec), 32'h1);
    chk({tag, "_cnt"}, 32'(dut.bit_cnt), 32'h0);
    chk({tag, "_sr"}, 32'(dut.u_sipo.sr), 32'h0);
    chk({tag, "_dout"}, 32'(dut.dout_parallel), 32'h0);
    chk({tag, "_trig"}, 32'(dut.trigger), 32'h0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    n_pass = 0;
    n_chk  = 0;
    n_trig = 0;
    model_reset();
    reset_i = 1'b1;

    repeat (2) @(negedge clk);
    chk_reset_state("reset");
    reset_i = 1'b0;

    // First word: MSB-first fill, single trigger after edge 24.
    tick();
    chk("sr_after_edge1", 32'(dut.u_sipo.sr), 32'h000000);
    repeat (W-1) tick();
    chk("first_trig_count", 32'(n_trig), 32'd1);
    chk("first_dout", 32'(dut.dout_parallel), 32'h000001);
    chk("first_sr", 32'(dut.u_sipo.sr), 32'h000001);
    chk("first_data", 32'(dut.data_in_vec), 32'h000002);

    // Ten more words back to back; per-cycle checks cover spacing and hold.
    n_trig = 0;
    repeat (10 * W) tick();
    chk("ten_word_trig_count", 32'(n_trig), 32'd10);
    chk("ten_word_last_dout", 32'(dut.dout_parallel), 32'd11);

    // Wrap-around: transmit all-ones, generator must roll to zero.
    force dut.data_in_vec = 24'hFFFFFF;
    m_word = 24'hFFFFFF;
    repeat (W-1) tick();
    release dut.data_in_vec;
    tick();
    chk("wrap_dout", 32'(dut.dout_parallel), 32'hFFFFFF);
    chk("wrap_data", 32'(dut.data_in_vec), 32'h000000);
    repeat (W) tick();
    chk("wrap_next_dout", 32'(dut.dout_parallel), 32'h000000);

    // Reset in the middle of a word, between clock edges.
    repeat (12) tick();
    chk("pre_reset_cnt", 32'(dut.bit_cnt), 32'd12);
    #3;
    reset_i = 1'b1;
    #1;
    chk_reset_state("midword_reset");
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("trig_during_reset", 32'(dut.trigger), 32'h0);
      chk("cnt_during_reset", 32'(dut.bit_cnt), 32'h0);
    end
    @(negedge clk);
    reset_i = 1'b0;
    model_reset();
    n_trig = 0;
    repeat (W) tick();
    chk("post_reset_trig_count", 32'(n_trig), 32'd1);
    chk("post_reset_dout", 32'(dut.dout_parallel), 32'h000001);
    repeat (W) tick();
    chk("post_reset_second_dout", 32'(dut.dout_parallel), 32'h000002);

    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
